// File: rtl/gcore_mc.sv
// gcore_mc: multi-cycle accumulator CPU (FETCH/EXEC per instruction) with
// program RAM, data RAM, an integrated valid/ready loader and start/halted
// run control.
//
// Handshake: the loader writes on every rising edge where load_valid and
// load_ready are both 1. load_ready is 1 only in HALT. load_valid may be held
// or dropped at any time. No write happens while load_ready is 0.
module gcore_mc #(
  parameter int DATA_W = 8,
  parameter int MEM_AW = 4,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic              load_sel,
  input  logic [PC_W-1:0]   load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  output logic              halted,
  output logic              illegal,
  output logic [DATA_W-1:0] acc_out,
  output logic [PC_W-1:0]   pc_out
);

  localparam int IW         = 4 + MEM_AW;
  localparam int PROG_DEPTH = 1 << PC_W;
  localparam int DATA_DEPTH = 1 << MEM_AW;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDM = 4'h1;
  localparam logic [3:0] OP_LDI = 4'h2;
  localparam logic [3:0] OP_STM = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_SHL = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_BZ  = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hC;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  // FSM state, kept as a named enum so checkers can bind to it directly
  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0] acc;
  logic [PC_W-1:0]   pc;
  logic [IW-1:0]     ir;
  logic              illegal_q;

  logic [IW-1:0]     prog_mem [PROG_DEPTH];
  logic [DATA_W-1:0] data_mem [DATA_DEPTH];

  logic              load_fire;
  logic [3:0]        opc;
  logic [MEM_AW-1:0] a_fld;
  logic [DATA_W-1:0] m;
  logic [31:0]       shamt;

  logic [DATA_W-1:0] exec_acc;
  logic [PC_W-1:0]   exec_pc;
  logic              exec_stm;
  logic              exec_halt;
  logic              exec_trap;

  assign load_fire = load_valid & load_ready;
  assign opc       = ir[IW-1 -: 4];
  assign a_fld     = ir[MEM_AW-1:0];
  // Combinational read so an LDM right after an STM sees the stored value
  assign m         = data_mem[a_fld];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_HALT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; start only matters in HALT
  always_comb begin
    state_nxt = state;
    case (state)
      ST_HALT:  if (start) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = (exec_halt || exec_trap) ? ST_HALT : ST_FETCH;
      default:  state_nxt = ST_HALT;
    endcase
  end

  // FSM outputs and architectural state views
  always_comb begin
    halted     = (state == ST_HALT);
    load_ready = (state == ST_HALT);
    illegal    = illegal_q;
    acc_out    = acc;
    pc_out     = pc;
  end

  // Instruction execute: results applied only when the FSM is in EXEC
  always_comb begin
    exec_acc  = acc;
    exec_pc   = pc;
    exec_stm  = 1'b0;
    exec_halt = 1'b0;
    exec_trap = 1'b0;
    shamt     = 32'(a_fld) % 32'(DATA_W);
    case (opc)
      OP_NOP: ;
      OP_LDM: exec_acc = m;
      OP_LDI: exec_acc = DATA_W'(a_fld);
      OP_STM: exec_stm = 1'b1;
      OP_ADD: exec_acc = acc + m;
      OP_SUB: exec_acc = acc - m;
      OP_AND: exec_acc = acc & m;
      OP_OR:  exec_acc = acc | m;
      OP_XOR: exec_acc = acc ^ m;
      OP_SHL: exec_acc = acc << shamt;
      OP_JMP: exec_pc  = m[PC_W-1:0];
      // acc here is the value before this instruction retires
      OP_BZ:  if (acc == '0) exec_pc = m[PC_W-1:0];
      OP_HLT: exec_halt = 1'b1;
      default: exec_trap = 1'b1;
    endcase
  end

  // Architectural registers: acc, pc, ir and the sticky illegal flag
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      pc        <= '0;
      ir        <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        ST_HALT: begin
          if (start) begin
            pc        <= '0;
            illegal_q <= 1'b0;
          end
        end
        ST_FETCH: begin
          ir <= prog_mem[pc];
          pc <= pc + PC_W'(1);
        end
        ST_EXEC: begin
          acc <= exec_acc;
          pc  <= exec_pc;
          if (exec_trap) illegal_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Program RAM: written only through the loader
  always_ff @(posedge clk) begin
    if (load_fire && !load_sel) begin
      prog_mem[load_addr] <= load_data[IW-1:0];
    end
  end

  // Data RAM: loader writes in HALT, STM writes in EXEC (never both);
  // an STM coinciding with rst is dropped
  always_ff @(posedge clk) begin
    if (load_fire && load_sel) begin
      data_mem[load_addr[MEM_AW-1:0]] <= load_data;
    end else if ((state == ST_EXEC) && exec_stm && !rst) begin
      data_mem[a_fld] <= acc;
    end
  end

endmodule
